// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: buffers an IMG_W x IMG_H raster and streams a WIN x WIN fit/zoom window with backpressure.
// Optional horizontal mirror (cmd 7) is built only when LCD_MIRROR_EN is defined.
module lcd_win_ctrl #(
   parameter int DW    = 8,
   parameter int IMG_W = 12,
   parameter int IMG_H = 9,
   parameter int WIN   = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [DW-1:0] datain,
   input  logic [2:0]    cmd,
   input  logic          cmd_valid,
   input  logic          out_ready,
   output logic [DW-1:0] dataout,
   output logic          output_valid,
   output logic          busy
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;

   localparam logic [AW-1:0] X_MAX   = AW'(IMG_W - WIN);
   localparam logic [AW-1:0] Y_MAX   = AW'(IMG_H - WIN);
   localparam logic [AW-1:0] X_CTR   = AW'((IMG_W - WIN) / 2);
   localparam logic [AW-1:0] Y_CTR   = AW'((IMG_H - WIN + 1) / 2);
   localparam logic [AW-1:0] ROW_W   = AW'(IMG_W);
   localparam logic [AW-1:0] SX      = AW'(IMG_W / WIN);
   localparam logic [AW-1:0] SY      = AW'(IMG_H / WIN);
   localparam logic [AW-1:0] SX_H    = AW'((IMG_W / WIN) / 2);
   localparam logic [AW-1:0] SY_H    = AW'((IMG_H / WIN) / 2);
   localparam logic [AW-1:0] LD_LAST = AW'(NPIX - 1);
   localparam logic [CW-1:0] C_LAST  = CW'(WIN - 1);

   localparam logic [2:0] C_LOAD   = 3'd0;
   localparam logic [2:0] C_ZIN    = 3'd1;
   localparam logic [2:0] C_FIT    = 3'd2;
   localparam logic [2:0] C_RIGHT  = 3'd3;
   localparam logic [2:0] C_LEFT   = 3'd4;
   localparam logic [2:0] C_UP     = 3'd5;
   localparam logic [2:0] C_DOWN   = 3'd6;
   localparam logic [2:0] C_MIRROR = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PREP = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef enum logic {
      M_FIT  = 1'b0,
      M_ZOOM = 1'b1
   } mode_t;

   logic [DW-1:0] buf_mem [NPIX];

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [AW-1:0] x0_q, x0_d, y0_q, y0_d;
   logic [AW-1:0] ld_cnt_q, ld_cnt_d;
   logic [CW-1:0] row_q, row_d, col_q, col_d;
   logic [DW-1:0] dataout_q, dataout_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
`ifdef LCD_MIRROR_EN
   logic          mirror_q, mirror_d;
`endif

   logic [CW-1:0] nrow_s, ncol_s, colm_s;
   logic [AW-1:0] addr_s;
   logic          xfer_s, last_s;

   // Address of the next window pixel to present: (0,0) from PREP, else raster successor.
   always_comb begin
      nrow_s = row_q;
      ncol_s = col_q;
      if (state_q == S_PREP) begin
         nrow_s = CW'(0);
         ncol_s = CW'(0);
      end else if (col_q == C_LAST) begin
         nrow_s = row_q + CW'(1);
         ncol_s = CW'(0);
      end else begin
         ncol_s = col_q + CW'(1);
      end
`ifdef LCD_MIRROR_EN
      colm_s = mirror_q ? (C_LAST - ncol_s) : ncol_s;
`else
      colm_s = ncol_s;
`endif
      if (mode_q == M_ZOOM) begin
         addr_s = (y0_q + AW'(nrow_s)) * ROW_W + x0_q + AW'(colm_s);
      end else begin
         addr_s = (SY * AW'(nrow_s) + SY_H) * ROW_W + SX * AW'(colm_s) + SX_H;
      end
   end

   // Command decode, load sequencing and output handshake.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      ld_cnt_d  = ld_cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      dataout_d = dataout_q;
      valid_d   = valid_q;
`ifdef LCD_MIRROR_EN
      mirror_d  = mirror_q;
`endif
      xfer_s    = valid_q && out_ready;
      last_s    = (row_q == C_LAST) && (col_q == C_LAST);
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_PREP;
               case (cmd)
                  C_LOAD: begin
                     state_d  = S_LOAD;
                     ld_cnt_d = AW'(0);
                     mode_d   = M_FIT;
`ifdef LCD_MIRROR_EN
                     mirror_d = 1'b0;
`endif
                  end
                  C_ZIN: begin
                     if (mode_q == M_FIT) begin
                        x0_d = X_CTR;
                        y0_d = Y_CTR;
                     end else begin
                        x0_d = x0_q;
                     end
                     mode_d = M_ZOOM;
                  end
                  C_FIT: mode_d = M_FIT;
                  C_RIGHT: begin
                     if ((mode_q == M_ZOOM) && (x0_q < X_MAX)) x0_d = x0_q + AW'(1);
                     else x0_d = x0_q;
                  end
                  C_LEFT: begin
                     if ((mode_q == M_ZOOM) && (x0_q > AW'(0))) x0_d = x0_q - AW'(1);
                     else x0_d = x0_q;
                  end
                  C_UP: begin
                     if ((mode_q == M_ZOOM) && (y0_q > AW'(0))) y0_d = y0_q - AW'(1);
                     else y0_d = y0_q;
                  end
                  C_DOWN: begin
                     if ((mode_q == M_ZOOM) && (y0_q < Y_MAX)) y0_d = y0_q + AW'(1);
                     else y0_d = y0_q;
                  end
                  C_MIRROR: begin
`ifdef LCD_MIRROR_EN
                     mirror_d = ~mirror_q;
`else
                     state_d = S_IDLE;
`endif
                  end
                  default: state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (ld_cnt_q == LD_LAST) begin
               state_d  = S_PREP;
               ld_cnt_d = AW'(0);
            end else begin
               ld_cnt_d = ld_cnt_q + AW'(1);
            end
         end
         S_PREP: begin
            row_d     = CW'(0);
            col_d     = CW'(0);
            dataout_d = buf_mem[addr_s];
            valid_d   = 1'b1;
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (xfer_s && last_s) begin
               valid_d = 1'b0;
               state_d = S_DONE;
            end else if (xfer_s) begin
               row_d     = nrow_s;
               col_d     = ncol_s;
               dataout_d = buf_mem[addr_s];
            end else begin
               valid_d = valid_q;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Image buffer is intentionally outside reset so a reset keeps the last image.
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) begin
         buf_mem[ld_cnt_q] <= datain;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         mode_q    <= M_FIT;
         x0_q      <= X_CTR;
         y0_q      <= Y_CTR;
         ld_cnt_q  <= AW'(0);
         row_q     <= CW'(0);
         col_q     <= CW'(0);
         dataout_q <= DW'(0);
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef LCD_MIRROR_EN
         mirror_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         x0_q      <= x0_d;
         y0_q      <= y0_d;
         ld_cnt_q  <= ld_cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         dataout_q <= dataout_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
`ifdef LCD_MIRROR_EN
         mirror_q  <= mirror_d;
`endif
      end
   end

   assign dataout      = dataout_q;
   assign output_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Self-checking bench for lcd_win_ctrl: behavioural window model, randomized commands/backpressure,
// and literal pins of the default-geometry sequences.
module tb_lcd_win_ctrl;
   localparam int DW    = 8;
   localparam int IMG_W = 12;
   localparam int IMG_H = 9;
   localparam int WIN   = 4;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NWIN  = WIN * WIN;
   localparam int X_MAX = IMG_W - WIN;
   localparam int Y_MAX = IMG_H - WIN;
   localparam int X_CTR = (IMG_W - WIN) / 2;
   localparam int Y_CTR = (IMG_H - WIN + 1) / 2;
   localparam int LIMIT = 500;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] datain;
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic          out_ready;
   logic [DW-1:0] dataout;
   logic          output_valid;
   logic          busy;

   lcd_win_ctrl #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
      .clk(clk), .reset_n(reset_n), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
      .out_ready(out_ready), .dataout(dataout), .output_valid(output_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_xfer = 0;
   int cmd_xfers = 0;
   int rdy_mode = 0;
   int stall_left = 0;
   bit load_index = 1'b1;

   logic [DW-1:0] img [NPIX];
   logic [DW-1:0] expq[$];
   logic [DW-1:0] got[$];
   logic [DW-1:0] stall_seen[$];

   bit zoom_m = 1'b0;
   bit mir_m  = 1'b0;
   int x0_m   = X_CTR;
   int y0_m   = Y_CTR;

   bit            prev_valid = 1'b0;
   bit            prev_ready = 1'b0;
   logic [DW-1:0] prev_data;

   int fit_lit  [NWIN] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
   int zoom_lit [NWIN] = '{40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67, 76, 77, 78, 79};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_list(input string name, input int lst [NWIN]);
      chk({name, "_len"}, got.size(), NWIN);
      for (int i = 0; i < NWIN && i < got.size(); i++) chk(name, got[i], lst[i]);
   endtask

   // Window pixel (r,c) straight from the geometry rules and the bench's copy of the image.
   function automatic logic [DW-1:0] exp_pix(input int r, input int c);
      int cc;
      int idx;
      cc = mir_m ? (WIN - 1 - c) : c;
      if (zoom_m) idx = (y0_m + r) * IMG_W + x0_m + cc;
      else idx = ((IMG_H / WIN) * r + (IMG_H / WIN) / 2) * IMG_W + (IMG_W / WIN) * cc + (IMG_W / WIN) / 2;
      return img[idx];
   endfunction

   function automatic bit model_cmd(input int c);
      bit outp = 1'b1;
      case (c)
         0: begin zoom_m = 1'b0; mir_m = 1'b0; end
         1: begin
            if (!zoom_m) begin x0_m = X_CTR; y0_m = Y_CTR; end
            zoom_m = 1'b1;
         end
         2: zoom_m = 1'b0;
         3: if (zoom_m && x0_m < X_MAX) x0_m++;
         4: if (zoom_m && x0_m > 0) x0_m--;
         5: if (zoom_m && y0_m > 0) y0_m--;
         6: if (zoom_m && y0_m < Y_MAX) y0_m++;
         default: begin
`ifdef LCD_MIRROR_EN
            mir_m = !mir_m;
`else
            outp = 1'b0;
`endif
         end
      endcase
      return outp;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream: always ready, random, or a scripted 3-cycle stall on the third pixel.
   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         1: out_ready = 1'($urandom_range(0, 1));
         2: begin
            if (output_valid && cmd_xfers == 2 && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
               stall_seen.push_back(dataout);
            end else begin
               out_ready = 1'b1;
            end
         end
         default: out_ready = 1'b1;
      endcase
   end

   // Compare process: every cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", output_valid, 1);
            chk("hold_data", dataout, prev_data);
         end
         if (output_valid) chk("valid_implies_busy", busy, 1);
         if (output_valid && out_ready) begin
            chk("pixel_expected", expq.size() > 0, 1);
            if (expq.size() > 0) chk("pixel", dataout, expq.pop_front());
            got.push_back(dataout);
            cmd_xfers++;
            last_xfer = cyc + 1;
         end
         prev_valid = output_valid;
         prev_ready = out_ready;
         prev_data  = dataout;
      end else begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end
   end

   task automatic run_cmd(input int c, input int rmode, input bit poke);
      bit outp;
      int t;
      logic [DW-1:0] ld [NPIX];
      rdy_mode = rmode;
      for (int i = 0; i < NPIX; i++) ld[i] = load_index ? DW'(i) : DW'($urandom);
      cmd       = 3'(c);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd       = 3'($urandom_range(0, 7));
      outp      = model_cmd(c);
      got.delete();
      cmd_xfers = 0;
      if (!outp) begin
         chk("noop_busy", busy, 0);
         repeat (3) begin
            @(posedge clk);
            #1;
            chk("noop_valid", output_valid, 0);
            chk("noop_busy_hold", busy, 0);
         end
      end else begin
         chk("busy_rise", busy, 1);
         chk("valid_before_first", output_valid, 0);
         if (c == 0) begin
            for (int i = 0; i < NPIX; i++) begin
               datain = ld[i];
               img[i] = ld[i];
               @(posedge clk);
               #1;
            end
            datain = DW'($urandom);
            chk("load_no_early_valid", output_valid, 0);
         end
         for (int r = 0; r < WIN; r++)
            for (int cc = 0; cc < WIN; cc++) expq.push_back(exp_pix(r, cc));
         @(posedge clk);
         #1;
         chk("first_valid", output_valid, 1);
         if (poke) begin
            cmd       = 3'($urandom_range(0, 7));
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
         end
         t = 0;
         while (busy && t < LIMIT) begin
            @(posedge clk);
            #1;
            t++;
         end
         chk("busy_bounded", t < LIMIT, 1);
         chk("busy_fall_cycle", cyc, last_xfer + 1);
         chk("xfer_count", cmd_xfers, NWIN);
         chk("queue_drained", expq.size(), 0);
         expq.delete();
      end
      rdy_mode = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int firsts [5];
      int c;
      reset_n   = 1'b0;
      datain    = '0;
      cmd       = 3'd0;
      cmd_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dataout", dataout, 0);
      chk("rst_valid", output_valid, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      load_index = 1'b1;
      run_cmd(0, 0, 1'b0);
      chk_list("fit_index", fit_lit);

      stall_left = 3;
      stall_seen.delete();
      run_cmd(1, 2, 1'b1);
      chk_list("zoom_centre", zoom_lit);
      chk("stall_cycles", stall_seen.size(), 3);
      foreach (stall_seen[i]) chk("stall_data", stall_seen[i], 42);

      for (int k = 0; k < 5; k++) begin
         run_cmd(3, 0, 1'b0);
         firsts[k] = (got.size() > 0) ? int'(got[0]) : -1;
      end
      chk("right1", firsts[0], 41);
      chk("right3", firsts[2], 43);
      chk("right4", firsts[3], 44);
      chk("right5_sat", firsts[4], 44);

      repeat (6) run_cmd(5, 0, 1'b0);
      chk("up6_sat", (got.size() > 0) ? int'(got[0]) : -1, 8);

      run_cmd(2, 1, 1'b0);
      chk_list("fit_again", fit_lit);
      run_cmd(4, 1, 1'b0);
      chk_list("fit_after_left", fit_lit);
      run_cmd(1, 0, 1'b0);
      chk("zoom_restart_centre", (got.size() > 0) ? int'(got[0]) : -1, 40);

      run_cmd(7, 0, 1'b0);
`ifdef LCD_MIRROR_EN
      chk("mirror_p0", (got.size() > 4) ? int'(got[0]) : -1, 43);
      chk("mirror_p1", (got.size() > 4) ? int'(got[1]) : -1, 42);
      chk("mirror_p3", (got.size() > 4) ? int'(got[3]) : -1, 40);
      chk("mirror_p4", (got.size() > 4) ? int'(got[4]) : -1, 55);
`endif

      load_index = 1'b0;
      for (int k = 0; k < 50; k++) begin
         c = $urandom_range(0, 7);
         if (c == 0 && $urandom_range(0, 2) != 0) c = 2;
         run_cmd(c, 1, 1'($urandom_range(0, 1)));
      end

      cmd       = 3'd2;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      void'(model_cmd(2));
      got.delete();
      cmd_xfers = 0;
      for (int r = 0; r < WIN; r++)
         for (int cc = 0; cc < WIN; cc++) expq.push_back(exp_pix(r, cc));
      repeat (6) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_valid", output_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_dataout", dataout, 0);
      expq.delete();
      zoom_m = 1'b0;
      mir_m  = 1'b0;
      x0_m   = X_CTR;
      y0_m   = Y_CTR;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_cmd(2, 0, 1'b0);
      run_cmd(3, 0, 1'b0);
      run_cmd(1, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/lcd_win_ctrl.md
# lcd_win_ctrl

Parametrised image-window display controller: second generation of the team's LCD control block. Loads a raster image of IMG_W×IMG_H pixels serially into an internal buffer. Streams a WIN×WIN window to the LCD driver, either as a zoom-fit subsample or as a pannable zoom-in crop. Adds generic image and window geometry, per-pixel output backpressure, and an optional horizontal-mirror mode.

## Interface
- DW, 8, pixel data width
- IMG_W, 12, image width in pixels (≥ WIN)
- IMG_H, 9, image height in pixels (≥ WIN)
- WIN, 4, window side length (≥ 1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- datain  in  DW  serial pixel input, raster order, during load
- cmd  in  3  command code
- cmd_valid  in  1  command strobe
- out_ready  in  1  downstream accepts dataout this cycle
- dataout  out  DW  window pixel
- output_valid  out  1  dataout holds a valid pixel
- busy  out  1  command in progress; commands ignored

## Operation
- Accept command when cmd_valid && !busy; else ignore (no queueing).
- Commands:
  - 0 Load: capture IMG_W*IMG_H pixels, then output; mode=FIT, mirror=0.
  - 1 Zoom in: from FIT reset origin to centre; from ZOOM keep origin; mode=ZOOM; output.
  - 2 Zoom fit: mode=FIT; output.
  - 3/4/5/6 Right/Left/Up/Down: in ZOOM move origin by 1 with saturation; in FIT origin unchanged; always output.
  - 7: see Configuration.
- Window origin (x0,y0) = top-left pixel:
  - Centre = ((IMG_W-WIN)/2, (IMG_H-WIN+1)/2), i.e. (4,3) at defaults.
  - Ranges x0 ∈ [0, IMG_W-WIN], y0 ∈ [0, IMG_H-WIN]; a shift at a limit is a no-op but still outputs.
- ZOOM pixel (r,c), r,c ∈ [0,WIN-1] → buffer[(y0+r)*IMG_W + x0+c].
- FIT pixel (r,c) → buffer[(SY*r+SY/2)*IMG_W + SX*c+SX/2], with SX=IMG_W/WIN and SY=IMG_H/WIN (integer division).
- Output order is raster within the window: r outer, c inner; WIN*WIN pixels per command.
- Address width: $clog2(IMG_W*IMG_H); all index arithmetic is unsigned at that width, with no overflow for legal parameters.
- Buffer is not cleared by reset; dataout before the first load is undefined data but output_valid is still correct.
- FSM states:
  - IDLE: accepts commands.
  - LOAD: counter 0..IMG_W*IMG_H-1.
  - PREP: one cycle, computes first address.
  - OUT: pixel counter 0..WIN*WIN-1.
  - DONE: one cycle, returns to IDLE.
- FSM transitions:
  - IDLE→LOAD on cmd 0.
  - IDLE→PREP on any other output-producing command.
  - LOAD→PREP after the last pixel.
  - PREP→OUT.
  - OUT→DONE after the last handshake.
  - DONE→IDLE.

## Timing
- Reset: dataout=0, output_valid=0, busy=0, mode=FIT, mirror=0, origin=centre, state=IDLE.
- Reset asserted mid-operation aborts immediately to these values; a partial load leaves the buffer partially overwritten.
- Command accepted in cycle T → busy=1 from T+1.
- Load: datain sampled on each of the IMG_W*IMG_H consecutive cycles T+1…T+N, with no gaps allowed.
- Non-load: PREP in T+1; first output_valid=1 in T+2.
- Handshake: a pixel transfers on output_valid && out_ready. While out_ready=0, dataout and output_valid hold stable.
- With out_ready held at 1: one pixel per cycle, 16 cycles at WIN=4.
- Cycle after the last transfer: output_valid=0, busy=1 (DONE). Next cycle busy=0, and a new command can be accepted there.
- Origin, mode and mirror update at acceptance and are stable during output.

## Configuration
- LCD_MIRROR_EN defined: cmd 7 toggles mirror and outputs the window. When mirror=1, column index c becomes WIN-1-c in both FIT and ZOOM. Load clears mirror.
- LCD_MIRROR_EN undefined: cmd 7 is accepted as a no-op. No busy, no output, no state change, and no mirror logic is synthesised.

## Test plan
- Load with datain=index (0..107, defaults) → 16 outputs 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy falls 2 cycles after the last pixel.
- Zoom in after load → 40,41,42,43,52,53,54,55,64,65,66,67,76,77,78,79.
- 5× Shift Right in ZOOM → 4th and 5th outputs both start at 44 (x0 saturates at 8); 6× Shift Up → first pixel 8 (y0=0).
- out_ready low during pixel 3 for 3 cycles → dataout=42 held with output_valid=1; exactly 16 transfers; commands during busy are ignored.
- Shift Left in FIT mode → fit sequence repeated unchanged; a following Zoom in restarts at centre (first pixel 40).
- LCD_MIRROR_EN: cmd 7 in ZOOM → 43,42,41,40,55,…; without the macro busy stays 0. Reset_n pulse mid-output → output_valid=0 and busy=0 immediately.
